// File: rtl/alu_chrom_decoder_pkg.sv
// Shared types and constants for the ALU chromosome decoder.
// Holds the chromosome bundle, FSM states, LFSR taps and movi encodings.
package alu_chrom_pkg;

   localparam int          LFSR_W    = 16;
   // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          RANGE_W   = 3;
   localparam int          DLY_W     = 4;

   localparam logic [1:0] MOVI_B   = 2'b00;
   localparam logic [1:0] MOVI_MEM = 2'b01;
   localparam logic [1:0] MOVI_IMM = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      SEND,
      FIN
   } state_t;

   typedef struct packed {
      logic [7:0]  opa;
      logic [7:0]  opb;
      logic [15:0] op;
      logic [2:0]  movi;
      logic [3:0]  dly;
   } chrom_t;

   function automatic logic [1:0] movi_enc(input logic [1:0] idx);
      case (idx)
         2'd1:    return MOVI_MEM;
         2'd2:    return MOVI_IMM;
         default: return MOVI_B;
      endcase
   endfunction

endpackage

// File: rtl/alu_chrom_decoder_range_pick.sv
// Range picker: first set mask bit at or after a start index, with wrap.
// Ports: mask_i (allowed ranges), idx_i (start index), sel_o (chosen index).
module range_pick #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask_i,
   input  logic [IW-1:0] idx_i,
   output logic [IW-1:0] sel_o
);

   logic [N-1:0] eff;

   // an empty mask means "no restriction"
   assign eff = (mask_i == '0) ? '1 : mask_i;

   always_comb begin
      int            s;
      int            p;
      logic [IW-1:0] pw;
      logic          found;
      sel_o = '0;
      found = 1'b0;
      s     = (int'(idx_i) >= N) ? 0 : int'(idx_i);
      for (int k = 0; k < N; k++) begin
         p = s + k;
         if (p >= N) p = p - N;
         pw = IW'(p);
         if (!found && eff[pw]) begin
            sel_o = pw;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_chrom_decoder.sv
// Chromosome decoder: replays range-constrained ALU transactions on a valid/ready stream.
// Ports: CHROM_* masks + CHROM_LOAD, START in; TX_* stream, BUSY, DONE out.
module alu_chrom_decoder
   import alu_chrom_pkg::*;
#(
   parameter int          DATA_WIDTH  = 8,
   parameter int          TRANS_COUNT = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CHROM_LOAD,
   input  logic [7:0]            CHROM_OPA_MASK,
   input  logic [7:0]            CHROM_OPB_MASK,
   input  logic [15:0]           CHROM_OP_MASK,
   input  logic [2:0]            CHROM_MOVI_MASK,
   input  logic [3:0]            CHROM_DELAY_MASK,
   input  logic                  START,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic [3:0]            TX_OP,
   output logic [1:0]            TX_MOVI,
   output logic [DATA_WIDTH-1:0] TX_OPA,
   output logic [DATA_WIDTH-1:0] TX_OPB,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int         LOW_W = DATA_WIDTH - RANGE_W;
   localparam logic [7:0] TC8   = 8'(TRANS_COUNT);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   state_t            state_q;
   chrom_t            chrom_q, chrom_in, chrom_use;
   logic [DLY_W-1:0]  dcnt_q, dly;
   logic [7:0]        tcnt_q;
   logic [2:0]        a_rng_q, b_rng_q, a_sel, b_sel;
   logic [3:0]        op_q, op_sel;
   logic [1:0]        mv_q, mv_sel, mv_idx, dr_sel;
   logic              tx_valid_q, busy_q, done_q;
   logic [3:0]        tx_op_q;
   logic [1:0]        tx_movi_q;
   logic [DATA_WIDTH-1:0] tx_opa_q, tx_opb_q;
   logic [LOW_W-1:0]  lo_a, lo_b;
   logic              idle_c, load_c, hs, last, draw;

   assign lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]}
                 ^ (lfsr_q[0] ? LFSR_TAPS : '0);

   always_comb begin
      chrom_in      = '0;
      chrom_in.opa  = CHROM_OPA_MASK;
      chrom_in.opb  = CHROM_OPB_MASK;
      chrom_in.op   = CHROM_OP_MASK;
      chrom_in.movi = CHROM_MOVI_MASK;
      chrom_in.dly  = CHROM_DELAY_MASK;
   end

   assign idle_c = (state_q == IDLE);
   assign load_c = idle_c && CHROM_LOAD;
   // a load in the start cycle feeds the picks directly
   assign chrom_use = load_c ? chrom_in : chrom_q;
   assign mv_idx = (lfsr_q[11:10] == 2'd3) ? 2'd0 : lfsr_q[11:10];

   range_pick #(.N(8)) u_pick_a (
      .mask_i(chrom_use.opa), .idx_i(lfsr_q[2:0]), .sel_o(a_sel));
   range_pick #(.N(8)) u_pick_b (
      .mask_i(chrom_use.opb), .idx_i(lfsr_q[5:3]), .sel_o(b_sel));
   range_pick #(.N(16)) u_pick_op (
      .mask_i(chrom_use.op), .idx_i(lfsr_q[9:6]), .sel_o(op_sel));
   range_pick #(.N(3)) u_pick_mv (
      .mask_i(chrom_use.movi), .idx_i(mv_idx), .sel_o(mv_sel));
   range_pick #(.N(4)) u_pick_dly (
      .mask_i(chrom_use.dly), .idx_i(lfsr_q[13:12]), .sel_o(dr_sel));

   assign dly  = {dr_sel, lfsr_q[15:14]};
   assign lo_a = lfsr_q[LOW_W-1:0];
   assign lo_b = lfsr_q[2*LOW_W-1:LOW_W];
   assign hs   = tx_valid_q && TX_READY;
   assign last = ((tcnt_q + 8'd1) == TC8);
   assign draw = (idle_c && START)
              || ((state_q == SEND) && hs && !last);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lfsr_q     <= LFSR_SEED;
         state_q    <= IDLE;
         chrom_q    <= '0;
         dcnt_q     <= '0;
         tcnt_q     <= '0;
         a_rng_q    <= '0;
         b_rng_q    <= '0;
         op_q       <= '0;
         mv_q       <= '0;
         tx_valid_q <= 1'b0;
         tx_op_q    <= '0;
         tx_movi_q  <= '0;
         tx_opa_q   <= '0;
         tx_opb_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         if (load_c) chrom_q <= chrom_in;
         if (hs) tcnt_q <= tcnt_q + 8'd1;
         else if (state_q == FIN) tcnt_q <= '0;
         if (draw) begin
            a_rng_q <= a_sel;
            b_rng_q <= b_sel;
            op_q    <= op_sel;
            mv_q    <= mv_sel;
            busy_q  <= 1'b1;
            // zero delay goes straight to SEND
            if (dly == '0) begin
               state_q    <= SEND;
               tx_valid_q <= 1'b1;
               tx_opa_q   <= {a_sel, lo_a};
               tx_opb_q   <= {b_sel, lo_b};
               tx_op_q    <= op_sel;
               tx_movi_q  <= movi_enc(mv_sel);
            end else begin
               state_q    <= DELAY;
               dcnt_q     <= dly - 4'd1;
               tx_valid_q <= 1'b0;
            end
         end else begin
            unique case (state_q)
               IDLE: ;
               DELAY: begin
                  if (dcnt_q == '0) begin
                     state_q    <= SEND;
                     tx_valid_q <= 1'b1;
                     tx_opa_q   <= {a_rng_q, lo_a};
                     tx_opb_q   <= {b_rng_q, lo_b};
                     tx_op_q    <= op_q;
                     tx_movi_q  <= movi_enc(mv_q);
                  end else begin
                     dcnt_q <= dcnt_q - 4'd1;
                  end
               end
               SEND: begin
                  if (hs) begin
                     state_q    <= FIN;
                     tx_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end
               FIN: begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign TX_VALID = tx_valid_q;
   assign TX_OP    = tx_op_q;
   assign TX_MOVI  = tx_movi_q;
   assign TX_OPA   = tx_opa_q;
   assign TX_OPB   = tx_opb_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_alu_chrom_decoder.sv
// Self-checking bench for alu_chrom_decoder.
// Random masks/ready against a rule-level model of draws, delays and operands.
module tb_alu_chrom_decoder;

   localparam int          DW   = 8;
   localparam int          TC   = 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          CHROM_LOAD = 1'b0;
   logic [7:0]    CHROM_OPA_MASK = '0;
   logic [7:0]    CHROM_OPB_MASK = '0;
   logic [15:0]   CHROM_OP_MASK = '0;
   logic [2:0]    CHROM_MOVI_MASK = '0;
   logic [3:0]    CHROM_DELAY_MASK = '0;
   logic          START = 1'b0;
   logic          TX_READY = 1'b0;
   logic          TX_VALID;
   logic [3:0]    TX_OP;
   logic [1:0]    TX_MOVI;
   logic [DW-1:0] TX_OPA, TX_OPB;
   logic          BUSY, DONE;

   always #5 CLK = ~CLK;

   alu_chrom_decoder #(
      .DATA_WIDTH(DW), .TRANS_COUNT(TC), .LFSR_SEED(SEED)
   ) dut (
      .CLK(CLK), .RESET(RESET), .CHROM_LOAD(CHROM_LOAD),
      .CHROM_OPA_MASK(CHROM_OPA_MASK), .CHROM_OPB_MASK(CHROM_OPB_MASK),
      .CHROM_OP_MASK(CHROM_OP_MASK), .CHROM_MOVI_MASK(CHROM_MOVI_MASK),
      .CHROM_DELAY_MASK(CHROM_DELAY_MASK), .START(START),
      .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_OP(TX_OP),
      .TX_MOVI(TX_MOVI), .TX_OPA(TX_OPA), .TX_OPB(TX_OPB),
      .BUSY(BUSY), .DONE(DONE)
   );

   int n_run = 0;
   int n_fail = 0;

   logic [15:0] m_lfsr;
   logic [7:0]  m_oa = '0, m_ob = '0;
   logic [15:0] m_op = '0;
   logic [2:0]  m_mv = '0;
   logic [3:0]  m_dl = '0;

   int q_gap[$];
   int q_opa[$];
   int q_opb[$];
   int q_op[$];
   int q_mv[$];
   int n_done;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      int          ex[4] = '{16, 14, 13, 11};
      logic [15:0] poly = '0;
      foreach (ex[i]) poly = poly | (16'd1 << (ex[i] - 1));
      return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
   endfunction

   always @(posedge CLK) m_lfsr <= RESET ? SEED : lfsr_step(m_lfsr);

   function automatic int pick(input int mask, input int n, input int idx);
      int m = (mask == 0) ? ((1 << n) - 1) : mask;
      int s = (idx >= n) ? 0 : idx;
      for (int k = 0; k < n; k++) begin
         int p = (s + k) % n;
         if (((m >> p) & 1) != 0) return p;
      end
      return 0;
   endfunction

   function automatic void predict(input logic [15:0] rnd, output int d,
         output int ea, output int eb, output int eo, output int em);
      int a, b, dr;
      logic [15:0] s;
      a  = pick(int'(m_oa), 8, int'(rnd[2:0]));
      b  = pick(int'(m_ob), 8, int'(rnd[5:3]));
      eo = pick(int'(m_op), 16, int'(rnd[9:6]));
      em = pick(int'(m_mv), 3, int'(rnd[11:10]));
      dr = pick(int'(m_dl), 4, int'(rnd[13:12]));
      d  = 4 * dr + int'(rnd[15:14]);
      s  = rnd;
      for (int i = 0; i < d; i++) s = lfsr_step(s);
      ea = a * 32 + int'(s[4:0]);
      eb = b * 32 + int'(s[9:5]);
   endfunction

   // mode 0: no load, 1: load then start, 2: load with start
   task automatic exec_run(input int mode, input logic [7:0] oa,
         input logic [7:0] ob, input logic [15:0] op, input logic [2:0] mv,
         input logic [3:0] dl, input int rdy);
      logic [15:0] rnd;
      int d, ea, eb, eo, em, k, w;
      logic [7:0] s_a, s_b;
      logic [3:0] s_o;
      logic [1:0] s_m;
      q_gap.delete(); q_opa.delete(); q_opb.delete();
      q_op.delete(); q_mv.delete(); n_done = 0;
      CHROM_OPA_MASK = oa; CHROM_OPB_MASK = ob; CHROM_OP_MASK = op;
      CHROM_MOVI_MASK = mv; CHROM_DELAY_MASK = dl;
      if (mode == 1) begin
         CHROM_LOAD = 1'b1;
         @(negedge CLK);
         CHROM_LOAD = 1'b0;
      end
      if (mode != 0) begin
         m_oa = oa; m_ob = ob; m_op = op; m_mv = mv; m_dl = dl;
      end
      CHROM_LOAD = (mode == 2);
      START = 1'b1;
      TX_READY = 1'b0;
      rnd = m_lfsr;
      for (int n = 0; n < TC; n++) begin
         predict(rnd, d, ea, eb, eo, em);
         k = 0;
         do begin
            @(negedge CLK);
            START = 1'b0; CHROM_LOAD = 1'b0; TX_READY = 1'b0;
            k++;
         end while (!TX_VALID && k < 20);
         n_run++;
         if (k != d + 1 || TX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL latency got %0d want %0d valid=%b", k, d + 1, TX_VALID);
         end
         n_run++;
         if (TX_OPA !== 8'(ea) || TX_OPB !== 8'(eb)) begin
            n_fail++;
            $display("FAIL operands got %0d/%0d want %0d/%0d", TX_OPA, TX_OPB, ea, eb);
         end
         n_run++;
         if (TX_OP !== 4'(eo) || TX_MOVI !== 2'(em)) begin
            n_fail++;
            $display("FAIL op_movi got %0d/%0d want %0d/%0d", TX_OP, TX_MOVI, eo, em);
         end
         n_run++;
         if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_mid got busy=%b done=%b want 1/0", BUSY, DONE);
         end
         q_gap.push_back(k);
         q_opa.push_back(int'(TX_OPA));
         q_opb.push_back(int'(TX_OPB));
         q_op.push_back(int'(TX_OP));
         q_mv.push_back(int'(TX_MOVI));
         w = 0;
         while ($urandom_range(99) >= rdy && w < 8) begin
            s_a = TX_OPA; s_b = TX_OPB; s_o = TX_OP; s_m = TX_MOVI;
            @(negedge CLK);
            w++;
            n_run++;
            if (TX_VALID !== 1'b1 || TX_OPA !== s_a || TX_OPB !== s_b
                || TX_OP !== s_o || TX_MOVI !== s_m) begin
               n_fail++;
               $display("FAIL hold got v=%b %0d/%0d want 1 %0d/%0d",
                        TX_VALID, TX_OPA, TX_OPB, s_a, s_b);
            end
         end
         TX_READY = 1'b1;
         rnd = m_lfsr;
      end
      @(negedge CLK);
      TX_READY = 1'b0;
      n_run++;
      if (DONE !== 1'b1 || BUSY !== 1'b1 || TX_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse got done=%b busy=%b v=%b want 1/1/0", DONE, BUSY, TX_VALID);
      end
      if (DONE === 1'b1) n_done++;
      @(negedge CLK);
      n_run++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || TX_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after got done=%b busy=%b v=%b want 0/0/0", DONE, BUSY, TX_VALID);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      n_run++;
      if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", TX_VALID); end
      n_run++;
      if (TX_OP !== 4'd0) begin n_fail++; $display("FAIL rst_op got %0d want 0", TX_OP); end
      n_run++;
      if (TX_MOVI !== 2'd0) begin n_fail++; $display("FAIL rst_movi got %0d want 0", TX_MOVI); end
      n_run++;
      if (TX_OPA !== 8'd0 || TX_OPB !== 8'd0) begin
         n_fail++; $display("FAIL rst_opnd got %0d/%0d want 0/0", TX_OPA, TX_OPB);
      end
      n_run++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", BUSY); end
      n_run++;
      if (DONE !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", DONE); end
      RESET = 1'b0;
      m_oa = '0; m_ob = '0; m_op = '0; m_mv = '0; m_dl = '0;
      @(negedge CLK);
   endtask

   task automatic test_hold();
      logic [15:0] rnd;
      int d, ea, eb, eo, em, k, got;
      logic [7:0] s_a, s_b;
      logic [3:0] s_o;
      logic [1:0] s_m;
      START = 1'b1;
      TX_READY = 1'b0;
      rnd = m_lfsr;
      predict(rnd, d, ea, eb, eo, em);
      k = 0;
      do begin
         @(negedge CLK);
         START = 1'b0;
         k++;
      end while (!TX_VALID && k < 20);
      n_run++;
      if (k != d + 1 || TX_VALID !== 1'b1) begin
         n_fail++; $display("FAIL hold_latency got %0d want %0d", k, d + 1);
      end
      n_run++;
      if (TX_OPA !== 8'(ea) || TX_OPB !== 8'(eb) || TX_OP !== 4'(eo)) begin
         n_fail++;
         $display("FAIL hold_first got %0d/%0d/%0d want %0d/%0d/%0d",
                  TX_OPA, TX_OPB, TX_OP, ea, eb, eo);
      end
      for (int c = k; c < 20; c++) begin
         s_a = TX_OPA; s_b = TX_OPB; s_o = TX_OP; s_m = TX_MOVI;
         if (c == k + 1) begin
            CHROM_OPA_MASK = 8'h01; CHROM_DELAY_MASK = 4'b0001;
            CHROM_LOAD = 1'b1; START = 1'b1;
         end
         @(negedge CLK);
         CHROM_LOAD = 1'b0; START = 1'b0;
         n_run++;
         if (TX_VALID !== 1'b1 || TX_OPA !== s_a || TX_OPB !== s_b
             || TX_OP !== s_o || TX_MOVI !== s_m || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable got v=%b %0d/%0d want 1 %0d/%0d",
                     TX_VALID, TX_OPA, TX_OPB, s_a, s_b);
         end
      end
      TX_READY = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1) got = 1;
      end
      TX_READY = 1'b0;
      n_run++;
      if (got != 1) begin n_fail++; $display("FAIL hold_done got %0d want 1", got); end
      @(negedge CLK);
      n_run++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL hold_idle got %b want 0", BUSY); end
      // masks must still be the reset (all-open) ones
      exec_run(0, 8'h00, 8'h00, 16'h0, 3'b0, 4'b0, 70);
   endtask

   task automatic test_single_bit();
      exec_run(1, 8'h04, 8'h80, 16'h0008, 3'b010, 4'b0001, 100);
      n_run++;
      if (q_opa.size() != TC || n_done != 1) begin
         n_fail++; $display("FAIL sb_count got %0d/%0d want %0d/1", q_opa.size(), n_done, TC);
      end
      foreach (q_opa[i]) begin
         n_run++;
         if (q_opa[i] < 64 || q_opa[i] > 95 || q_opb[i] < 224
             || q_op[i] != 3 || q_mv[i] != 1) begin
            n_fail++;
            $display("FAIL sb_fields got %0d/%0d/%0d/%0d want [64,95]/>=224/3/1",
                     q_opa[i], q_opb[i], q_op[i], q_mv[i]);
         end
         n_run++;
         if (q_gap[i] < 1 || q_gap[i] > 4) begin
            n_fail++; $display("FAIL sb_gap got %0d want 1..4", q_gap[i]);
         end
      end
   endtask

   task automatic test_max_delay();
      exec_run(1, 8'($urandom), 8'($urandom), 16'($urandom), 3'($urandom),
               4'b1000, 60);
      foreach (q_gap[i]) begin
         n_run++;
         if (q_gap[i] < 13 || q_gap[i] > 16) begin
            n_fail++; $display("FAIL maxdly_gap got %0d want 13..16", q_gap[i]);
         end
      end
   endtask

   task automatic test_load_start();
      for (int r = 0; r < 3; r++) begin
         exec_run(2, 8'h01, 8'($urandom), 16'($urandom), 3'($urandom),
                  4'($urandom), int'($urandom_range(30, 100)));
         foreach (q_opa[i]) begin
            n_run++;
            if (q_opa[i] > 31) begin
               n_fail++; $display("FAIL ldst_opa got %0d want <=31", q_opa[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 8; r++) begin
         exec_run(int'($urandom_range(0, 2)),
                  ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom),
                  8'($urandom), 16'($urandom), 3'($urandom),
                  ($urandom_range(1) == 0) ? 4'b0001 : 4'($urandom),
                  int'($urandom_range(20, 100)));
      end
   endtask

   task automatic test_reset_mid();
      int k, bad;
      CHROM_OPA_MASK = 8'($urandom); CHROM_DELAY_MASK = 4'b0011;
      CHROM_LOAD = 1'b1; START = 1'b1; TX_READY = 1'b0;
      k = 0;
      do begin
         @(negedge CLK);
         CHROM_LOAD = 1'b0; START = 1'b0;
         k++;
      end while (!TX_VALID && k < 20);
      n_run++;
      if (TX_VALID !== 1'b1) begin n_fail++; $display("FAIL rm_valid got %b want 1", TX_VALID); end
      RESET = 1'b1;
      @(negedge CLK);
      n_run++;
      if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_abort got v=%b busy=%b done=%b want 0/0/0", TX_VALID, BUSY, DONE);
      end
      RESET = 1'b0;
      CHROM_OPA_MASK = 8'h01; CHROM_OPB_MASK = 8'h00; CHROM_OP_MASK = 16'h0;
      CHROM_MOVI_MASK = 3'b0; CHROM_DELAY_MASK = 4'b0;
      CHROM_LOAD = 1'b1;
      m_oa = 8'h01; m_ob = '0; m_op = '0; m_mv = '0; m_dl = '0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         CHROM_LOAD = 1'b0;
         if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
      end
      n_run++;
      if (bad != 0) begin n_fail++; $display("FAIL rm_nodone got %0d want 0", bad); end
      exec_run(0, 8'h00, 8'h00, 16'h0, 3'b0, 4'b0, 80);
      foreach (q_opa[i]) begin
         n_run++;
         if (q_opa[i] > 31) begin
            n_fail++; $display("FAIL rm_reload got %0d want <=31", q_opa[i]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hold();
      test_single_bit();
      test_max_delay();
      test_load_start();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
